ad9958_sweep_sequencer: RTL and testbench
=========================================

Name: ad9958_sweep_sequencer

Overview:
Drives the ftw_ch0/ftw_ch1/asf_ch0/asf_ch1 inputs of the AD9958 core so the two DDS channels step through a linear frequency sweep. It advances one sweep point per programmable number of io_update pulses emitted by the core. Sits between the host configuration registers and the core. The core samples its inputs on the rising edge of io_update, so this block may only change its outputs just after an io_update pulse.

Parameters:
STEP_WIDTH, 16, width of num_steps and step_index.
DWELL_WIDTH, 16, width of the dwell count, measured in io_update pulses per sweep point.

Ports:
clock  in  1  system clock; io_update is synchronous to it.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; begins a sweep when in IDLE.
abort  in  1  one-cycle pulse; stops the sweep.
static_load  in  1  in IDLE only: copy the start/ASF inputs directly to the outputs.
repeat_en  in  1  1 = restart the sweep after the last point; 0 = single sweep.
ftw_start_ch0  in  32  ch0 start FTW.
ftw_step_ch0  in  32  ch0 per-point increment, two's complement.
ftw_start_ch1  in  32  ch1 start FTW.
ftw_step_ch1  in  32  ch1 per-point increment, two's complement.
asf_ch0_in  in  32  ch0 ASF word, held constant for the whole sweep.
asf_ch1_in  in  32  ch1 ASF word, held constant for the whole sweep.
num_steps  in  STEP_WIDTH  number of increments after the start point (the sweep has num_steps+1 points).
dwell  in  DWELL_WIDTH  io_update pulses per point; 0 is treated as 1.
io_update  in  1  io_update pulse from the core.
ftw_ch0, ftw_ch1, asf_ch0, asf_ch1  out  32 each  registered words to the core.
step_index  out  STEP_WIDTH  current point number.
busy  out  1  high in the LOAD and RUN states.
done  out  1  one-cycle pulse when a single sweep completes.

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0; internal shadow registers and counters 0.
- Edge detect: upd = io_update & ~io_update_d, where io_update_d is a register. Only upd advances the sweep, so a multi-cycle io_update counts once.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 -> LOAD. In the same cycle, latch all config inputs into shadow registers.
  - Config inputs are ignored after this point until the next start.
  - static_load=1 with start=0: outputs take the start FTWs and ASF inputs next cycle; state stays IDLE.
  - start and static_load together: start wins.
- LOAD (1 cycle):
  - Outputs take the shadow start FTWs and ASFs.
  - step_index=0, dwell_cnt=0.
  - If shadow num_steps=0: -> DONE, with the outputs still loaded. Otherwise -> RUN.
- RUN, on upd:
  - If dwell_cnt < eff_dwell-1: dwell_cnt++.
  - Otherwise dwell_cnt=0, then:
    - If step_index < num_steps: ftw_chN += step_chN (modulo 2^32, wrap allowed, no saturation); step_index++.
    - Else if repeat_en_shadow: outputs reload the start FTWs; step_index=0.
    - Else: -> DONE.
  - Outputs change on the cycle after upd. The core therefore samples the new value at the following io_update.
  - Without upd, all state holds.
- DONE (1 cycle): done=1; -> IDLE. Outputs hold the final point.
- abort, in any non-IDLE state: -> IDLE next cycle.
  - Outputs and step_index hold; done is not asserted.
  - abort beats start and upd in the same cycle.
- start while busy: ignored.
- busy=1 exactly in LOAD and RUN. done is 0 except in DONE.
- Reset mid-sweep: asynchronous return to reset values; the core then sees FTW/ASF 0 at its next io_update.

Decomposition:
- Include file ad9958_sweep_vars.vh holds:
  - state encodings SWEEP_IDLE=0, SWEEP_LOAD=1, SWEEP_RUN=2, SWEEP_DONE=3;
  - the default widths.
- Sub-module ad9958_ftw_accumulator, instantiated once per channel:
  - inputs clock, reset, load, load_value, step_en, step;
  - output value, a 32-bit register;
  - load has priority over step_en.
- The top level holds the FSM, edge detect, dwell counter, step counter and shadow registers.

Test Plan:
1. Reset with io_update idle, then start. Config: ftw_start_ch0=0x1000_0000, step_ch0=0x100, ftw_start_ch1=0x2000_0000, step_ch1=-0x100, num_steps=3, dwell=1, repeat_en=0.
   - Pulse io_update 4 times.
   - ch0 reaches 0x1000_0100, 0x1000_0200, 0x1000_0300; ch1 mirrors downward.
   - On the 4th pulse: done pulses for 1 cycle, busy falls, outputs hold 0x1000_0300.
2. dwell=3, num_steps=1: ftw_ch0 changes only after the 3rd pulse. step_index goes 0->1, and the sweep completes after the 6th pulse.
3. ftw_start_ch0=0xFFFF_FF00, step=0x200, num_steps=1: ftw_ch0 reaches 0x0000_0100 (wrap); no error indication.
4. repeat_en=1, num_steps=2, dwell=1: after the 3rd pulse, outputs return to start values and step_index=0; done is never asserted. Then abort: busy=0 next cycle, outputs hold.
5. Change ftw_step_ch0 mid-sweep: no effect. start while busy: ignored. abort and start in the same cycle: state goes to IDLE.
6. num_steps=0: busy high for the LOAD cycle only; done pulses; outputs equal the start values. Separately, assert reset during RUN: all outputs read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ad9958_sweep_sequencer_pkg.sv
// rtl/ad9958_sweep_sequencer_pkg.sv - shared state encoding and default widths for the sweep sequencer
package ad9958_sweep_sequencer_pkg;

    localparam int STEP_WIDTH_DEFAULT  = 16;
    localparam int DWELL_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        SWEEP_IDLE = 2'd0,
        SWEEP_LOAD = 2'd1,
        SWEEP_RUN  = 2'd2,
        SWEEP_DONE = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/ad9958_ftw_accumulator.sv
// rtl/ad9958_ftw_accumulator.sv - per-channel frequency tuning word register with load and modulo-2^32 step
module ad9958_ftw_accumulator (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        step_en,
    input  logic [31:0] step,
    output logic [31:0] value
);

    // Load wins over step; the add wraps freely so downward sweeps use a two's complement step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= 32'd0;
        end else if (load) begin
            value <= load_value;
        end else if (step_en) begin
            value <= value + step;
        end
    end

endmodule

// File: rtl/ad9958_sweep_sequencer.sv
// rtl/ad9958_sweep_sequencer.sv - linear two-channel FTW sweep paced by io_update pulses from the AD9958 core
module ad9958_sweep_sequencer
    import ad9958_sweep_sequencer_pkg::*;
#(
    parameter int STEP_WIDTH  = STEP_WIDTH_DEFAULT,
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   static_load,
    input  logic                   repeat_en,
    input  logic [31:0]            ftw_start_ch0,
    input  logic [31:0]            ftw_step_ch0,
    input  logic [31:0]            ftw_start_ch1,
    input  logic [31:0]            ftw_step_ch1,
    input  logic [31:0]            asf_ch0_in,
    input  logic [31:0]            asf_ch1_in,
    input  logic [STEP_WIDTH-1:0]  num_steps,
    input  logic [DWELL_WIDTH-1:0] dwell,
    input  logic                   io_update,
    output logic [31:0]            ftw_ch0,
    output logic [31:0]            ftw_ch1,
    output logic [31:0]            asf_ch0,
    output logic [31:0]            asf_ch1,
    output logic [STEP_WIDTH-1:0]  step_index,
    output logic                   busy,
    output logic                   done
);

    sweep_state_t state, state_next;

    logic                   io_update_d;
    logic                   upd;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic [DWELL_WIDTH-1:0] dwell_last;

    logic [31:0]            sh_start_ch0, sh_step_ch0, sh_start_ch1, sh_step_ch1;
    logic [31:0]            sh_asf_ch0, sh_asf_ch1;
    logic [STEP_WIDTH-1:0]  sh_num_steps;
    logic [DWELL_WIDTH-1:0] sh_dwell;
    logic                   sh_repeat;

    logic shadow_latch, acc_load, acc_from_input, acc_step;
    logic asf_from_input, asf_from_shadow;
    logic idx_clear, idx_inc, dwell_clear, dwell_inc;

    assign upd        = io_update & ~io_update_d;
    // A dwell of 0 behaves as 1, so the last count index is 0 in both cases.
    assign dwell_last = (sh_dwell == '0) ? '0 : sh_dwell - DWELL_WIDTH'(1);
    assign busy       = (state == SWEEP_LOAD) || (state == SWEEP_RUN);
    assign done       = (state == SWEEP_DONE);

    // State register plus the edge-detect delay flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= SWEEP_IDLE;
            io_update_d <= 1'b0;
        end else begin
            state       <= state_next;
            io_update_d <= io_update;
        end
    end

    // Next state and datapath strobes; abort pre-empts every other action outside IDLE.
    always_comb begin
        state_next      = state;
        shadow_latch    = 1'b0;
        acc_load        = 1'b0;
        acc_from_input  = 1'b0;
        acc_step        = 1'b0;
        asf_from_input  = 1'b0;
        asf_from_shadow = 1'b0;
        idx_clear       = 1'b0;
        idx_inc         = 1'b0;
        dwell_clear     = 1'b0;
        dwell_inc       = 1'b0;
        case (state)
            SWEEP_IDLE: begin
                if (start) begin
                    state_next   = SWEEP_LOAD;
                    shadow_latch = 1'b1;
                end else if (static_load) begin
                    acc_load       = 1'b1;
                    acc_from_input = 1'b1;
                    asf_from_input = 1'b1;
                end
            end
            SWEEP_LOAD: begin
                if (abort) begin
                    state_next = SWEEP_IDLE;
                end else begin
                    acc_load        = 1'b1;
                    asf_from_shadow = 1'b1;
                    idx_clear       = 1'b1;
                    dwell_clear     = 1'b1;
                    state_next      = (sh_num_steps == '0) ? SWEEP_DONE : SWEEP_RUN;
                end
            end
            SWEEP_RUN: begin
                if (abort) begin
                    state_next = SWEEP_IDLE;
                end else if (upd) begin
                    if (dwell_cnt < dwell_last) begin
                        dwell_inc = 1'b1;
                    end else begin
                        dwell_clear = 1'b1;
                        if (step_index < sh_num_steps) begin
                            acc_step = 1'b1;
                            idx_inc  = 1'b1;
                        end else if (sh_repeat) begin
                            acc_load  = 1'b1;
                            idx_clear = 1'b1;
                        end else begin
                            state_next = SWEEP_DONE;
                        end
                    end
                end
            end
            SWEEP_DONE: begin
                state_next = SWEEP_IDLE;
            end
            default: begin
                state_next = SWEEP_IDLE;
            end
        endcase
    end

    // Shadow configuration, captured only on an accepted start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_start_ch0 <= 32'd0;
            sh_step_ch0  <= 32'd0;
            sh_start_ch1 <= 32'd0;
            sh_step_ch1  <= 32'd0;
            sh_asf_ch0   <= 32'd0;
            sh_asf_ch1   <= 32'd0;
            sh_num_steps <= '0;
            sh_dwell     <= '0;
            sh_repeat    <= 1'b0;
        end else if (shadow_latch) begin
            sh_start_ch0 <= ftw_start_ch0;
            sh_step_ch0  <= ftw_step_ch0;
            sh_start_ch1 <= ftw_start_ch1;
            sh_step_ch1  <= ftw_step_ch1;
            sh_asf_ch0   <= asf_ch0_in;
            sh_asf_ch1   <= asf_ch1_in;
            sh_num_steps <= num_steps;
            sh_dwell     <= dwell;
            sh_repeat    <= repeat_en;
        end
    end

    // Point counter, dwell counter and ASF output words.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step_index <= '0;
            dwell_cnt  <= '0;
            asf_ch0    <= 32'd0;
            asf_ch1    <= 32'd0;
        end else begin
            if (idx_clear) begin
                step_index <= '0;
            end else if (idx_inc) begin
                step_index <= step_index + STEP_WIDTH'(1);
            end
            if (dwell_clear) begin
                dwell_cnt <= '0;
            end else if (dwell_inc) begin
                dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
            end
            if (asf_from_input) begin
                asf_ch0 <= asf_ch0_in;
                asf_ch1 <= asf_ch1_in;
            end else if (asf_from_shadow) begin
                asf_ch0 <= sh_asf_ch0;
                asf_ch1 <= sh_asf_ch1;
            end
        end
    end

    ad9958_ftw_accumulator u_acc_ch0 (
        .clock      (clock),
        .reset      (reset),
        .load       (acc_load),
        .load_value (acc_from_input ? ftw_start_ch0 : sh_start_ch0),
        .step_en    (acc_step),
        .step       (sh_step_ch0),
        .value      (ftw_ch0)
    );

    ad9958_ftw_accumulator u_acc_ch1 (
        .clock      (clock),
        .reset      (reset),
        .load       (acc_load),
        .load_value (acc_from_input ? ftw_start_ch1 : sh_start_ch1),
        .step_en    (acc_step),
        .step       (sh_step_ch1),
        .value      (ftw_ch1)
    );

endmodule

// File: tb/tb_ad9958_sweep_sequencer.sv
// tb/tb_ad9958_sweep_sequencer.sv - self-checking bench for the AD9958 sweep sequencer
module tb_ad9958_sweep_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        static_load = 1'b0;
    logic        repeat_en = 1'b0;
    logic [31:0] ftw_start_ch0 = '0, ftw_step_ch0 = '0, ftw_start_ch1 = '0, ftw_step_ch1 = '0;
    logic [31:0] asf_ch0_in = '0, asf_ch1_in = '0;
    logic [15:0] num_steps = '0, dwell = '0;
    logic        io_update = 1'b0;
    logic [31:0] ftw_ch0, ftw_ch1, asf_ch0, asf_ch1;
    logic [15:0] step_index;
    logic        busy, done;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model configuration (what the sweep was started with).
    logic [31:0] m_s0, m_st0, m_s1, m_st1, m_a0, m_a1;
    int          m_ns, m_dw;
    bit          m_rep;

    always #5 clock = ~clock;

    ad9958_sweep_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .static_load(static_load), .repeat_en(repeat_en),
        .ftw_start_ch0(ftw_start_ch0), .ftw_step_ch0(ftw_step_ch0),
        .ftw_start_ch1(ftw_start_ch1), .ftw_step_ch1(ftw_step_ch1),
        .asf_ch0_in(asf_ch0_in), .asf_ch1_in(asf_ch1_in),
        .num_steps(num_steps), .dwell(dwell), .io_update(io_update),
        .ftw_ch0(ftw_ch0), .ftw_ch1(ftw_ch1), .asf_ch0(asf_ch0), .asf_ch1(asf_ch1),
        .step_index(step_index), .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cfg(input logic [31:0] s0, st0, s1, st1, a0, a1,
                           input int ns, input int dw, input bit rep);
        ftw_start_ch0 = s0; ftw_step_ch0 = st0; ftw_start_ch1 = s1; ftw_step_ch1 = st1;
        asf_ch0_in = a0; asf_ch1_in = a1; num_steps = 16'(ns); dwell = 16'(dw); repeat_en = rep;
        m_s0 = s0; m_st0 = st0; m_s1 = s1; m_st1 = st1; m_a0 = a0; m_a1 = a1;
        m_ns = ns; m_dw = dw; m_rep = rep;
    endtask

    // start pulse, then the LOAD cycle; on return the sweep sits at its start point
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    // rising io_update held for len cycles; d/b are done/busy in the cycle right after the edge
    task automatic pulse(input int len, output logic d, output logic b);
        io_update = 1'b1;
        tick();
        d = done;
        b = busy;
        for (int i = 1; i < len; i++) tick();
        io_update = 1'b0;
        tick();
    endtask

    function automatic int eff_dwell();
        return (m_dw == 0) ? 1 : m_dw;
    endfunction

    // Sweep point reached after k counted io_update edges.
    function automatic int model_pt(int k);
        int pt;
        pt = k / eff_dwell();
        if (m_rep) pt = pt % (m_ns + 1);
        else if (pt > m_ns) pt = m_ns;
        return pt;
    endfunction

    function automatic bit model_done(int k);
        return !m_rep && (k == (m_ns + 1) * eff_dwell());
    endfunction

    function automatic logic [31:0] model_ftw(logic [31:0] s, logic [31:0] st, int pt);
        logic [31:0] p;
        p = pt;
        return s + st * p;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tests_run++;
        if ({ftw_ch0, ftw_ch1, asf_ch0, asf_ch1} !== 128'd0) begin
            tests_failed++;
            $display("FAIL reset_words got %h %h %h %h want all 0", ftw_ch0, ftw_ch1, asf_ch0, asf_ch1);
        end
        tests_run++;
        if ({step_index, busy, done} !== 18'd0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got idx=%0d busy=%b done=%b want 0 0 0", step_index, busy, done);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_sweep();
        logic d, b;
        set_cfg(32'h1000_0000, 32'h100, 32'h2000_0000, 32'hFFFF_FF00, 32'h3FF, 32'h155, 3, 1, 0);
        do_start();
        tests_run++;
        if (ftw_ch0 !== 32'h1000_0000 || ftw_ch1 !== 32'h2000_0000 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_load got %h %h busy=%b want 10000000 20000000 1", ftw_ch0, ftw_ch1, busy);
        end
        for (int k = 1; k <= 4; k++) begin
            pulse(1, d, b);
            tests_run++;
            if (ftw_ch0 !== model_ftw(m_s0, m_st0, model_pt(k)) || ftw_ch1 !== model_ftw(m_s1, m_st1, model_pt(k))) begin
                tests_failed++;
                $display("FAIL basic_ftw k=%0d got %h %h want %h %h", k, ftw_ch0, ftw_ch1,
                         model_ftw(m_s0, m_st0, model_pt(k)), model_ftw(m_s1, m_st1, model_pt(k)));
            end
            tests_run++;
            if (d !== model_done(k) || b !== !model_done(k) || step_index !== 16'(model_pt(k))) begin
                tests_failed++;
                $display("FAIL basic_ctrl k=%0d got done=%b busy=%b idx=%0d want %b %b %0d", k, d, b,
                         step_index, model_done(k), !model_done(k), model_pt(k));
            end
        end
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || ftw_ch0 !== 32'h1000_0300 || asf_ch0 !== 32'h3FF) begin
            tests_failed++;
            $display("FAIL basic_hold got done=%b busy=%b ftw0=%h asf0=%h want 0 0 10000300 3ff", done, busy, ftw_ch0, asf_ch0);
        end
    endtask

    task automatic test_dwell();
        logic d, b;
        set_cfg(32'h0000_1000, 32'h10, 32'h0, 32'h1, 32'h1, 32'h2, 1, 3, 0);
        do_start();
        for (int k = 1; k <= 6; k++) begin
            pulse((k == 2) ? 3 : 1, d, b);   // a long io_update still counts once
            tests_run++;
            if (ftw_ch0 !== model_ftw(m_s0, m_st0, model_pt(k)) || step_index !== 16'(model_pt(k)) ||
                d !== model_done(k)) begin
                tests_failed++;
                $display("FAIL dwell k=%0d got ftw0=%h idx=%0d done=%b want %h %0d %b", k, ftw_ch0, step_index, d,
                         model_ftw(m_s0, m_st0, model_pt(k)), model_pt(k), model_done(k));
            end
        end
    endtask

    task automatic test_wrap();
        logic d, b;
        set_cfg(32'hFFFF_FF00, 32'h200, 32'h5, 32'h0, 32'h0, 32'h0, 1, 1, 0);
        do_start();
        pulse(1, d, b);
        tests_run++;
        if (ftw_ch0 !== 32'h0000_0100 || b !== 1'b1 || d !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap got ftw0=%h busy=%b done=%b want 00000100 1 0", ftw_ch0, b, d);
        end
        pulse(1, d, b);
        tests_run++;
        if (d !== 1'b1 || ftw_ch0 !== 32'h0000_0100) begin
            tests_failed++;
            $display("FAIL wrap_done got done=%b ftw0=%h want 1 00000100", d, ftw_ch0);
        end
    endtask

    task automatic test_repeat_abort();
        logic d, b;
        logic [31:0] hold0;
        set_cfg(32'h4000_0000, 32'h1234, 32'h5000_0000, 32'h8000_0000, 32'hA, 32'hB, 2, 1, 1);
        do_start();
        for (int k = 1; k <= 5; k++) begin
            pulse(1, d, b);
            tests_run++;
            if (ftw_ch0 !== model_ftw(m_s0, m_st0, model_pt(k)) || ftw_ch1 !== model_ftw(m_s1, m_st1, model_pt(k)) ||
                step_index !== 16'(model_pt(k)) || d !== 1'b0 || b !== 1'b1) begin
                tests_failed++;
                $display("FAIL repeat k=%0d got %h %h idx=%0d done=%b busy=%b want %h %h %0d 0 1", k, ftw_ch0, ftw_ch1,
                         step_index, d, b, model_ftw(m_s0, m_st0, model_pt(k)), model_ftw(m_s1, m_st1, model_pt(k)),
                         model_pt(k));
            end
        end
        hold0 = ftw_ch0;
        abort = 1'b1;
        io_update = 1'b1;   // abort must beat a simultaneous update
        tick();
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || ftw_ch0 !== hold0 || step_index !== 16'(model_pt(5))) begin
            tests_failed++;
            $display("FAIL abort got busy=%b done=%b ftw0=%h idx=%0d want 0 0 %h %0d", busy, done, ftw_ch0, step_index,
                     hold0, model_pt(5));
        end
        io_update = 1'b0;
        tick();
        pulse(1, d, b);
        tests_run++;
        if (ftw_ch0 !== hold0 || b !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_hold got ftw0=%h busy=%b want %h 0", ftw_ch0, b, hold0);
        end
    endtask

    task automatic test_ignore_config();
        logic d, b;
        set_cfg(32'h100, 32'h10, 32'h200, 32'h20, 32'h7, 32'h8, 3, 1, 0);
        do_start();
        pulse(1, d, b);
        ftw_step_ch0 = 32'h9999;
        ftw_start_ch0 = 32'hDEAD_0000;
        pulse(1, d, b);
        tests_run++;
        if (ftw_ch0 !== model_ftw(m_s0, m_st0, 2) || step_index !== 16'd2) begin
            tests_failed++;
            $display("FAIL cfg_ignored got ftw0=%h idx=%0d want %h 2", ftw_ch0, step_index, model_ftw(m_s0, m_st0, 2));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tests_run++;
        if (ftw_ch0 !== model_ftw(m_s0, m_st0, 2) || step_index !== 16'd2 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_busy got ftw0=%h idx=%0d busy=%b want %h 2 1", ftw_ch0, step_index, busy,
                     model_ftw(m_s0, m_st0, 2));
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_start got busy=%b want 0", busy);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0 || ftw_ch0 !== model_ftw(m_s0, m_st0, 2)) begin
            tests_failed++;
            $display("FAIL abort_start_idle got busy=%b ftw0=%h want 0 %h", busy, ftw_ch0, model_ftw(m_s0, m_st0, 2));
        end
    endtask

    task automatic test_static_load();
        set_cfg(32'hCAFE_0001, 32'h1, 32'hBEEF_0002, 32'h1, 32'h11, 32'h22, 1, 1, 0);
        static_load = 1'b1;
        tick();
        static_load = 1'b0;
        tests_run++;
        if (ftw_ch0 !== 32'hCAFE_0001 || ftw_ch1 !== 32'hBEEF_0002 || asf_ch0 !== 32'h11 || asf_ch1 !== 32'h22 ||
            busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL static_load got %h %h %h %h busy=%b want cafe0001 beef0002 11 22 0", ftw_ch0, ftw_ch1,
                     asf_ch0, asf_ch1, busy);
        end
        start = 1'b1;
        static_load = 1'b1;
        tick();
        start = 1'b0;
        static_load = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_wins got busy=%b want 1", busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_zero_steps();
        set_cfg(32'h0ABC_0000, 32'h77, 32'h0DEF_0000, 32'h88, 32'h33, 32'h44, 0, 2, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_load got busy=%b done=%b want 1 0", busy, done);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b1 || ftw_ch0 !== m_s0 || ftw_ch1 !== m_s1 || asf_ch1 !== m_a1) begin
            tests_failed++;
            $display("FAIL zero_done got busy=%b done=%b %h %h %h want 0 1 %h %h %h", busy, done, ftw_ch0, ftw_ch1,
                     asf_ch1, m_s0, m_s1, m_a1);
        end
        tick();
        tests_run++;
        if (done !== 1'b0 || ftw_ch0 !== m_s0) begin
            tests_failed++;
            $display("FAIL zero_after got done=%b ftw0=%h want 0 %h", done, ftw_ch0, m_s0);
        end
    endtask

    task automatic test_async_reset();
        logic d, b;
        set_cfg(32'h1111_1111, 32'h1, 32'h2222_2222, 32'h1, 32'h5, 32'h6, 4, 1, 0);
        do_start();
        pulse(1, d, b);
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({ftw_ch0, ftw_ch1, asf_ch0, asf_ch1} !== 128'd0 || step_index !== 16'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset got %h %h %h %h idx=%0d busy=%b want zeros", ftw_ch0, ftw_ch1, asf_ch0,
                     asf_ch1, step_index, busy);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic d, b;
        int n;
        for (int it = 0; it < 8; it++) begin
            set_cfg($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            do_start();
            tests_run++;
            if (ftw_ch0 !== m_s0 || ftw_ch1 !== m_s1 || asf_ch0 !== m_a0 || asf_ch1 !== m_a1) begin
                tests_failed++;
                $display("FAIL rnd_start it=%0d got %h %h %h %h want %h %h %h %h", it, ftw_ch0, ftw_ch1, asf_ch0,
                         asf_ch1, m_s0, m_s1, m_a0, m_a1);
            end
            if (m_ns == 0) begin
                tests_run++;
                if (done !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rnd_zero it=%0d got done=%b want 1", it, done);
                end
                tick();
                continue;
            end
            n = m_rep ? int'($urandom_range(1, 14)) : (m_ns + 1) * eff_dwell();
            for (int k = 1; k <= n; k++) begin
                pulse(int'($urandom_range(1, 2)), d, b);
                tests_run++;
                if (ftw_ch0 !== model_ftw(m_s0, m_st0, model_pt(k)) || ftw_ch1 !== model_ftw(m_s1, m_st1, model_pt(k)) ||
                    step_index !== 16'(model_pt(k)) || d !== model_done(k) || b !== !model_done(k)) begin
                    tests_failed++;
                    $display("FAIL rnd it=%0d k=%0d got %h %h idx=%0d done=%b busy=%b want %h %h %0d %b %b", it, k,
                             ftw_ch0, ftw_ch1, step_index, d, b, model_ftw(m_s0, m_st0, model_pt(k)),
                             model_ftw(m_s1, m_st1, model_pt(k)), model_pt(k), model_done(k), !model_done(k));
                end
            end
            if (m_rep) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
            end
            tests_run++;
            if (busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL rnd_end it=%0d got busy=%b want 0", it, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_dwell();
        test_wrap();
        test_repeat_abort();
        test_ignore_config();
        test_static_load();
        test_zero_steps();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
